// File: rtl/condicionador_botoes_if.sv
// Button-conditioner bus: raw buttons and controller strobes in, clean play vector and pulses out.
interface condicionador_botoes_if;
    logic [8:0] botoes_in;
    logic       habilita;
    logic       limpa;
    logic [8:0] botoes;
    logic [3:0] posicao;
    logic       tem_jogada;
    logic       erro_multiplo;
    logic       db_estado;

    modport master (
        output botoes_in, habilita, limpa,
        input  botoes, posicao, tem_jogada, erro_multiplo, db_estado
    );

    modport slave (
        input  botoes_in, habilita, limpa,
        output botoes, posicao, tem_jogada, erro_multiplo, db_estado
    );
endinterface

// File: rtl/condicionador_botoes.sv
// Synchronises and debounces the 9 board buttons, accepting one single-button press
// at a time and holding off until every button has been released.
module condicionador_botoes #(
    parameter int N_DEBOUNCE = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    condicionador_botoes_if.slave bus
);
    localparam int CNT_W = $clog2(N_DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_DEBOUNCE - 1);

    typedef enum logic {
        OCIOSO       = 1'b0,
        ESPERA_SOLTA = 1'b1
    } estado_t;

    logic [8:0]       sinc_p0;
    logic [8:0]       sinc_p1;
    logic [8:0]       amostra;
    logic [8:0]       estavel;
    logic [CNT_W-1:0] cnt;
    estado_t          estado;
    logic [8:0]       botoes_r;
    logic [3:0]       posicao_r;
    logic             tem_jogada_r;
    logic             erro_multiplo_r;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    function automatic logic mais_de_um(input logic [8:0] v);
        return (v & (v - 9'd1)) != 9'd0;
    endfunction

    function automatic logic [3:0] indice(input logic [8:0] v);
        logic [3:0] idx;
        idx = 4'hF;
        for (int i = 0; i < 9; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            sinc_p0         <= '0;
            sinc_p1         <= '0;
            amostra         <= '0;
            estavel         <= '0;
            cnt             <= '0;
            estado          <= OCIOSO;
            botoes_r        <= '0;
            posicao_r       <= 4'hF;
            tem_jogada_r    <= 1'b0;
            erro_multiplo_r <= 1'b0;
        end else begin
            // p0 -> p1: two-flop synchroniser, then the shared debounce counter
            sinc_p0 <= bus.botoes_in;
            sinc_p1 <= sinc_p0;
            amostra <= sinc_p1;
            if (sinc_p1 != amostra) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                estavel <= sinc_p1;
            end

            // Acceptance stage: an accepted press overrides a simultaneous limpa
            tem_jogada_r    <= 1'b0;
            erro_multiplo_r <= 1'b0;
            if (bus.limpa) begin
                botoes_r  <= '0;
                posicao_r <= 4'hF;
            end
            if (estado == OCIOSO) begin
                if (estavel != 9'd0) begin
                    if (mais_de_um(estavel)) begin
                        erro_multiplo_r <= 1'b1;
                    end else if (bus.habilita) begin
                        botoes_r     <= estavel;
                        posicao_r    <= indice(estavel);
                        tem_jogada_r <= 1'b1;
                    end
                    estado <= ESPERA_SOLTA;
                end
            end else begin
                if (estavel == 9'd0) estado <= OCIOSO;
            end
        end
    end

    assign bus.botoes        = botoes_r;
    assign bus.posicao       = posicao_r;
    assign bus.tem_jogada    = tem_jogada_r;
    assign bus.erro_multiplo = erro_multiplo_r;
    assign bus.db_estado     = (estado == ESPERA_SOLTA);
endmodule

// File: tb/tb_condicionador_botoes.sv
// Scoreboard bench for condicionador_botoes: a window-based debounce model predicts pulses
// and latched outputs; a negedge monitor checks them against the DUT.
module tb_condicionador_botoes;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset;

    condicionador_botoes_if bus();

    condicionador_botoes #(.N_DEBOUNCE(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         ed;
        bit         kind;   // 0 = tem_jogada, 1 = erro_multiplo
    } ev_t;

    ev_t        exp_q[$];
    logic [8:0] hist[$];
    logic [8:0] m_est;
    logic [8:0] m_bot;
    logic [3:0] m_pos;
    bit         m_esp;
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         last_tj_edge = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: a value becomes stable once the raw input has held it for N+1
    // consecutive samples, seen through a two-edge synchroniser delay.
    task automatic model(input logic [8:0] raw, input bit hab, input bit lim, input bit rst);
        int  k;
        bit  same;
        ev_t e;
        if (rst) begin
            if (hist.size() > 0) hist[hist.size()-1] = '0;
            hist.push_back('0);
            m_est = '0;
            m_bot = '0;
            m_pos = 4'hF;
            m_esp = 0;
        end else begin
            hist.push_back(raw);
            if (lim) begin
                m_bot = '0;
                m_pos = 4'hF;
            end
            if (!m_esp) begin
                if (m_est != 0) begin
                    e.ed = cyc;
                    if ($countones(m_est) > 1) begin
                        e.kind = 1'b1;
                        exp_q.push_back(e);
                    end else if (hab) begin
                        m_bot  = m_est;
                        m_pos  = 4'($clog2(m_est));
                        e.kind = 1'b0;
                        exp_q.push_back(e);
                    end
                    m_esp = 1;
                end
            end else if (m_est == 0) begin
                m_esp = 0;
            end
            k = hist.size() - 1;
            if (k - 2 - N >= 0) begin
                same = 1;
                for (int j = k - 2 - N; j <= k - 2; j++)
                    if (hist[j] !== hist[k-2]) same = 0;
                if (same) m_est = hist[k-2];
            end
        end
    endtask

    task automatic step(input logic [8:0] raw, input bit hab, input bit lim, input bit rst);
        bus.botoes_in = raw;
        bus.habilita  = hab;
        bus.limpa     = lim;
        reset         = rst;
        @(posedge clock);
        cyc++;
        model(raw, hab, lim, rst);
        @(negedge clock);
    endtask

    task automatic hold(input logic [8:0] v, input bit hab, input bit lim, input int n);
        repeat (n) step(v, hab, lim, 1'b0);
    endtask

    always @(negedge clock) begin
        ev_t e;
        if (cyc > 0) begin
            check("db_estado", 32'(bus.db_estado), 32'(m_esp));
            check("botoes", 32'(bus.botoes), 32'(m_bot));
            check("posicao", 32'(bus.posicao), 32'(m_pos));
            check("pulse_exclusive", 32'(bus.tem_jogada & bus.erro_multiplo), 32'd0);
            if (bus.tem_jogada || bus.erro_multiplo) begin
                if (bus.tem_jogada) last_tj_edge = cyc;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pulse: tem_jogada=%b erro_multiplo=%b, expected none (edge %0d)",
                             bus.tem_jogada, bus.erro_multiplo, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_edge", 32'(cyc), 32'(e.ed));
                    check("pulse_kind", 32'(bus.erro_multiplo), 32'(e.kind));
                end
            end else if (exp_q.size() > 0 && exp_q[0].ed <= cyc) begin
                e = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missed_pulse: no pulse seen, expected kind %0d at edge %0d", e.kind, e.ed);
            end
        end
    end

    initial begin
        int p;
        logic [8:0] v;
        bit hab;
        m_est = '0; m_bot = '0; m_pos = 4'hF; m_esp = 0;

        repeat (3) step('0, 1'b0, 1'b0, 1'b1);
        check("reset_botoes", 32'(bus.botoes), 32'd0);
        check("reset_posicao", 32'(bus.posicao), 32'hF);
        check("reset_tem_jogada", 32'(bus.tem_jogada), 32'd0);
        check("reset_erro", 32'(bus.erro_multiplo), 32'd0);
        check("reset_estado", 32'(bus.db_estado), 32'd0);

        // Clean single press: pulse exactly N+3 edges after the first sampling edge
        hold('0, 1, 0, 3);
        p = cyc + 1;
        hold(9'h010, 1, 0, 20);
        check("s1_latency", 32'(last_tj_edge), 32'(p + N + 3));
        check("s1_botoes", 32'(bus.botoes), 32'h010);
        check("s1_posicao", 32'(bus.posicao), 32'd4);
        hold('0, 1, 0, N + 2);
        check("s1_still_waiting", 32'(bus.db_estado), 32'd1);
        hold('0, 1, 0, 8);
        check("s1_released", 32'(bus.db_estado), 32'd0);
        check("s1_botoes_held", 32'(bus.botoes), 32'h010);

        // Short glitches never become stable
        repeat (5) begin
            hold(9'h004, 1, 0, 3);
            hold('0, 1, 0, 3);
        end
        check("s2_estavel", 32'(dut.estavel), 32'd0);

        // Two buttons together, then a single one
        hold(9'h101, 1, 0, 15);
        hold('0, 1, 0, 12);
        p = cyc + 1;
        hold(9'h100, 1, 0, 15);
        check("s3_latency", 32'(last_tj_edge), 32'(p + N + 3));
        check("s3_posicao", 32'(bus.posicao), 32'd8);
        hold('0, 1, 0, 12);

        // Press consumed while disabled, accepted after release
        hold(9'h002, 0, 0, 10);
        hold(9'h002, 1, 0, 10);
        hold('0, 1, 0, 12);
        p = cyc + 1;
        hold(9'h002, 1, 0, 15);
        check("s4_latency", 32'(last_tj_edge), 32'(p + N + 3));
        check("s4_posicao", 32'(bus.posicao), 32'd1);
        hold('0, 1, 0, 12);

        // Second button while first still held is ignored
        hold(9'h008, 1, 0, 10);
        hold(9'h028, 1, 0, 15);
        hold('0, 1, 0, 12);
        hold(9'h020, 1, 0, 15);
        check("s5_botoes", 32'(bus.botoes), 32'h020);
        hold('0, 1, 0, 12);

        // limpa alone, limpa on the acceptance edge, reset mid-debounce
        hold(9'h040, 1, 0, 15);
        hold('0, 1, 0, 12);
        hold('0, 1, 1, 1);
        check("s6_limpa_botoes", 32'(bus.botoes), 32'd0);
        check("s6_limpa_posicao", 32'(bus.posicao), 32'hF);
        hold('0, 1, 0, 3);
        hold(9'h080, 1, 1, 15);
        hold('0, 1, 0, 12);
        hold(9'h001, 1, 0, 4);
        step(9'h001, 1, 0, 1);
        step(9'h001, 1, 0, 1);
        hold('0, 1, 0, 12);
        check("s6_reset_botoes", 32'(bus.botoes), 32'd0);

        // Randomised segments with sporadic limpa and reset
        repeat (80) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: v = '0;
                4, 5, 6, 7: v = 9'd1 << $urandom_range(0, 8);
                8:          v = (9'd1 << $urandom_range(0, 8)) | (9'd1 << $urandom_range(0, 8));
                default:    v = 9'($urandom_range(0, 511));
            endcase
            hab = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 14))
                step(v, hab, ($urandom_range(0, 15) == 0), ($urandom_range(0, 79) == 0));
        end

        hold('0, 1, 0, 15);
        check("pending_events", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
